std_spram_bw_init: RTL and testbench
====================================

Name: std_spram_bw_init

Overview:
- Parametrised single-port SRAM wrapper; next generation of the fixed-size std_spram family.
- Adds configurable width/depth, byte-write mask, optional output pipeline register, read-valid strobe and a self-clearing init sequencer.
- Serves NPU local buffers: weight, activation and scratch storage behind core load/store and DMA ports.
- Keeps the active-low CEB/WEB macro convention so it drops into existing instantiation sites.

Parameters:
- MEM_ADDR_WIDTH, 6: address width.
- MEM_DATA_WIDTH, 32: data width; must be a multiple of 8.
- MEM_DEPTH, 64: number of words; must satisfy MEM_DEPTH <= 2^MEM_ADDR_WIDTH.
- OUT_REG, 0: 1 adds an output register stage, making read latency 2.
- INIT_EN, 1: 1 zero-fills the whole array after every reset.

Ports:
- CLK  in  1  clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- CEB  in  1  chip enable, active low.
- WEB  in  1  write enable, active low; high means read.
- BWEB  in  MEM_DATA_WIDTH/8  byte write enable, active low; bit i covers D[8i+7:8i].
- A  in  MEM_ADDR_WIDTH  word address.
- D  in  MEM_DATA_WIDTH  write data.
- Q  out  MEM_DATA_WIDTH  read data.
- QVLD  out  1  one-cycle pulse marking new data on Q.
- INIT_BUSY  out  1  high while the init sequencer owns the array.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset values: Q=0, QVLD=0, init counter=0, output pipeline cleared. INIT_BUSY=1 if INIT_EN=1, else 0. Array contents are not reset.
- Access on a CLK edge: an access occurs only when CEB=0 and INIT_BUSY=0.
- Write: WEB=0. Each byte i with BWEB[i]=0 is written with D's byte i; other bytes are kept. BWEB all ones means a write with no effect.
- Read: WEB=1. BWEB is ignored.
- Out-of-range address (A >= MEM_DEPTH):
  - writes are dropped;
  - reads return 0 with the normal QVLD timing.
- Read latency, OUT_REG=0: read at edge N → Q and QVLD=1 valid after edge N+1 (one cycle).
- Read latency, OUT_REG=1: read at edge N → Q and QVLD=1 valid after edge N+2.
- QVLD is high for exactly one cycle per read. Back-to-back reads give continuous QVLD, one result per cycle, in order.
- Q holds its last read value until the next read result. Writes never change Q and do not pulse QVLD (no write-through).
- Read following a write to the same address on the next edge returns the new data.
- Init FSM, states INIT and RUN:
  - reset → INIT if INIT_EN=1, else RUN.
  - In INIT, each cycle writes all-zero to address cnt, then cnt increments.
  - When cnt = MEM_DEPTH-1 is written → RUN. INIT_BUSY falls on the edge that writes the last word, so INIT lasts exactly MEM_DEPTH cycles.
  - RUN is terminal until the next RST.
- User requests in INIT: silently dropped (no write, no QVLD). Callers must gate on INIT_BUSY.
- RST mid-init restarts cnt at 0.
- RST with a read in flight cancels it: QVLD=0, pipeline cleared.
- RST in RUN re-enters INIT (array is re-zeroed) when INIT_EN=1.
- Clock gating: CLK to the array may be gated with the codebase ICG, enable = (~CEB) | INIT_BUSY.
- Technology mapping:
  - Behavioural array under FPGA.
  - Under a technology define, a foundry macro with a per-bit mask expanded from BWEB.
  - Cycle behaviour is identical in every build.

Test Plan:
1. Init, defaults with INIT_EN=1. Hold RST 3 cycles, then release.
   - INIT_BUSY is high for exactly 64 cycles.
   - Reads of addresses 0, 31 and 63 return 0x00000000, each with a single QVLD pulse 1 cycle later.
2. Byte mask, OUT_REG=0.
   - Write 0xAABBCCDD to address 5 with BWEB=4'b0000.
   - Then write 0x11223344 to address 5 with BWEB=4'b1010.
   - Read address 5 → Q=0xAA22CC44.
3. Pipelined reads, OUT_REG=1. Array holds A[i]=i*3.
   - Issue reads of addresses 0..7 on consecutive cycles.
   - Q sequence is 0, 3, ..., 21, starting 2 cycles after the first request; QVLD stays high for 8 cycles.
4. Blocked during init.
   - Issue a write of 0xDEADBEEF to address 10 while INIT_BUSY=1, then read address 10 after init completes.
   - Read returns 0, and no QVLD pulse occurred during init.
5. Reset mid-operation, OUT_REG=1.
   - Issue a read, and assert RST the next cycle: no QVLD pulse, Q=0.
   - Assert RST at cnt=20 during init: INIT_BUSY stays high for a further 64 cycles.
6. Out of range, MEM_DEPTH=48 with MEM_ADDR_WIDTH=6.
   - Write 0x5 to address 50: the write has no effect on any word.
   - Read address 50 → Q=0 with QVLD.
   - Read address 47 after writing 0x7 → Q=0x7.

Source files
------------

// File: rtl/std_spram_bw_init.sv
// Parametrised single-port SRAM: byte-write mask, optional output register,
// read-valid strobe and a zero-fill init sequencer that runs after every reset.
module std_spram_bw_init #(
    parameter int MEM_ADDR_WIDTH = 6,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 64,
    parameter bit OUT_REG        = 1'b0,
    parameter bit INIT_EN        = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CEB,
    input  logic                        WEB,
    input  logic [MEM_DATA_WIDTH/8-1:0] BWEB,
    input  logic [MEM_ADDR_WIDTH-1:0]   A,
    input  logic [MEM_DATA_WIDTH-1:0]   D,
    output logic [MEM_DATA_WIDTH-1:0]   Q,
    output logic                        QVLD,
    output logic                        INIT_BUSY
);
    localparam int NB = MEM_DATA_WIDTH / 8;
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [MEM_ADDR_WIDTH:0] DEPTH_EXT = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_INIT  = 1'b1;
    localparam logic [0:0] ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

    if (MEM_DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("MEM_DATA_WIDTH must be a multiple of 8");
    end
    if (MEM_DEPTH > 2 ** MEM_ADDR_WIDTH) begin : g_bad_depth
        $error("MEM_DEPTH exceeds the address space");
    end

    logic [0:0]                state;
    logic [MEM_ADDR_WIDTH-1:0] cnt;
    logic                      acc_en;
    logic                      acc_we;
    logic                      in_range;
    logic [MEM_ADDR_WIDTH-1:0] acc_addr;
    logic [MEM_DATA_WIDTH-1:0] acc_wd;
    logic [MEM_DATA_WIDTH-1:0] acc_bm;
    logic [MEM_DATA_WIDTH-1:0] arr_rd;
    logic                      rd_v;

    assign INIT_BUSY = (state == ST_INIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= ST_RUN;
            end
        end
    end

    // The sequencer owns the port while busy; user requests are simply ignored.
    always_comb begin
        acc_en   = 1'b0;
        acc_we   = 1'b0;
        acc_addr = A;
        acc_wd   = D;
        acc_bm   = '0;
        if (!RST && INIT_BUSY) begin
            acc_en   = 1'b1;
            acc_we   = 1'b1;
            acc_addr = cnt;
            acc_wd   = '0;
            acc_bm   = '1;
        end else if (!RST && !CEB) begin
            acc_en = 1'b1;
            acc_we = !WEB;
            for (int i = 0; i < NB; i++) begin
                acc_bm[8*i +: 8] = {8{!BWEB[i]}};
            end
        end
    end

    assign in_range = {1'b0, acc_addr} < DEPTH_EXT;

`ifdef STD_SPRAM_MACRO
    logic                      arr_clk;
    logic                      oor_q;
    logic [MEM_DATA_WIDTH-1:0] macro_q;

    std_icg u_icg (
        .clk  (CLK),
        .en   (acc_en),
        .se   (1'b0),
        .gclk (arr_clk)
    );

    std_spram_macro #(
        .AW    (MEM_ADDR_WIDTH),
        .DW    (MEM_DATA_WIDTH),
        .DEPTH (MEM_DEPTH)
    ) u_macro (
        .CLK  (arr_clk),
        .CEB  (!(acc_en && in_range)),
        .WEB  (!acc_we),
        .BWEB (~acc_bm),
        .A    (acc_addr),
        .D    (acc_wd),
        .Q    (macro_q)
    );

    always_ff @(posedge CLK) begin
        if (acc_en && !acc_we) begin
            oor_q <= !in_range;
        end
    end

    assign arr_rd = oor_q ? '0 : macro_q;
`else
    logic [MEM_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge CLK) begin
        if (acc_en && in_range) begin
            if (acc_we) begin
                mem[acc_addr] <= (mem[acc_addr] & ~acc_bm) | (acc_wd & acc_bm);
            end else begin
                arr_rd <= mem[acc_addr];
            end
        end else if (acc_en && !acc_we) begin
            arr_rd <= '0;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_v <= 1'b0;
        end else begin
            rd_v <= acc_en && !acc_we;
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [MEM_DATA_WIDTH-1:0] q_r;
        logic                      v_r;

        always_ff @(posedge CLK) begin
            if (RST) begin
                q_r <= '0;
                v_r <= 1'b0;
            end else begin
                v_r <= rd_v;
                if (rd_v) begin
                    q_r <= arr_rd;
                end
            end
        end

        assign Q    = q_r;
        assign QVLD = v_r;
    end else begin : g_noreg
        // Array output is only trusted in the strobe cycle; hold covers the rest.
        logic [MEM_DATA_WIDTH-1:0] hold;

        always_ff @(posedge CLK) begin
            if (RST) begin
                hold <= '0;
            end else if (rd_v) begin
                hold <= arr_rd;
            end
        end

        assign Q    = rd_v ? arr_rd : hold;
        assign QVLD = rd_v;
    end

endmodule

// File: tb/tb_std_spram_bw_init.sv
// Scoreboard bench: three SRAM builds share one stimulus stream and are each
// checked against a word-array reference model with timed read expectations.
module tb_std_spram_bw_init;
    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    localparam int DEP  [3] = '{64, 64, 48};
    localparam int OREG [3] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ceb = 1'b1;
    logic        web = 1'b1;
    logic [3:0]  bweb = 4'hf;
    logic [5:0]  a = '0;
    logic [31:0] d = '0;
    logic [31:0] q    [3];
    logic        qvld [3];
    logic        busy [3];

    std_spram_bw_init #(.OUT_REG(1'b0)) u0 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d),
        .Q(q[0]), .QVLD(qvld[0]), .INIT_BUSY(busy[0])
    );
    std_spram_bw_init #(.OUT_REG(1'b1)) u1 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d),
        .Q(q[1]), .QVLD(qvld[1]), .INIT_BUSY(busy[1])
    );
    std_spram_bw_init #(.MEM_DEPTH(48)) u2 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d),
        .Q(q[2]), .QVLD(qvld[2]), .INIT_BUSY(busy[2])
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    bit          cnt_en = 1'b0;
    logic [31:0] mem_m [3][64];
    int          init_left [3] = '{0, 0, 0};
    logic [31:0] q_exp [3] = '{32'h0, 32'h0, 32'h0};
    int          busy_len [3];
    exp_t        sb [3][$];

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s u%0d cyc %0d: got %h required %h", nm, k, cyc, act, req);
        end
    endtask

    // Reference: words as plain arrays, init as a countdown, reads as timed tickets.
    task automatic model(int k, int e, bit r, bit cb, bit wb, logic [3:0] bw,
                         logic [5:0] ad, logic [31:0] dd);
        exp_t t;
        if (r) begin
            init_left[k] = DEP[k];
            q_exp[k] = 32'h0;
            while (sb[k].size() > 0 && sb[k][$].due >= e) begin
                void'(sb[k].pop_back());
            end
        end else if (init_left[k] > 0) begin
            mem_m[k][DEP[k] - init_left[k]] = 32'h0;
            init_left[k]--;
        end else if (!cb) begin
            if (!wb) begin
                if (int'(ad) < DEP[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (!bw[b]) mem_m[k][ad][8*b +: 8] = dd[8*b +: 8];
                    end
                end
            end else begin
                t.d = (int'(ad) < DEP[k]) ? mem_m[k][ad] : 32'h0;
                t.due = e + OREG[k];
                sb[k].push_back(t);
            end
        end
    endtask

    task automatic step(bit r, bit cb, bit wb, logic [3:0] bw,
                        logic [5:0] ad, logic [31:0] dd);
        @(negedge clk);
        if (cnt_en) begin
            for (int k = 0; k < 3; k++) busy_len[k] += int'(busy[k]);
        end
        rst = r; ceb = cb; web = wb; bweb = bw; a = ad; d = dd;
        for (int k = 0; k < 3; k++) model(k, cyc + 1, r, cb, wb, bw, ad, dd);
        chk_en = 1'b1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 4'hf, 6'd0, 32'h0);
    endtask

    task automatic wr(logic [5:0] ad, logic [31:0] dd, logic [3:0] bw);
        step(1'b0, 1'b0, 1'b0, bw, ad, dd);
    endtask

    task automatic rd(logic [5:0] ad);
        step(1'b0, 1'b0, 1'b1, 4'hf, ad, 32'h0);
    endtask

    task automatic measure_init(int n_before);
        for (int k = 0; k < 3; k++) busy_len[k] = 0;
        cnt_en = 1'b1;
        // Requests issued while the sequencer is busy must vanish.
        wr(6'd10, 32'hDEADBEEF, 4'h0);
        rd(6'd10);
        idle(70 - n_before);
        cnt_en = 1'b0;
        for (int k = 0; k < 3; k++) chk("init_len", k, 32'(busy_len[k]), 32'(DEP[k]));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    chk("init_busy", k, 32'(busy[k]), 32'(init_left[k] > 0));
                    if (qvld[k]) begin
                        if (sb[k].size() == 0) begin
                            chk("spurious_qvld", k, 32'(qvld[k]), 32'h0);
                        end else begin
                            e = sb[k].pop_front();
                            chk("q_data", k, q[k], e.d);
                            chk("q_latency", k, 32'(cyc), 32'(e.due));
                            q_exp[k] = e.d;
                        end
                    end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                        void'(sb[k].pop_front());
                        chk("missing_qvld", k, 32'(qvld[k]), 32'h1);
                    end
                    chk("q_hold", k, q[k], q_exp[k]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) step(1'b1, 1'b1, 1'b1, 4'hf, 6'd0, 32'h0);
        measure_init(0);

        rd(6'd0); rd(6'd31); rd(6'd63); idle(2);
        rd(6'd10); idle(3);

        wr(6'd5, 32'hAABBCCDD, 4'b0000);
        wr(6'd5, 32'h11223344, 4'b1010);
        rd(6'd5); idle(3);
        chk("byte_mask_model", 0, mem_m[0][5], 32'hAA22CC44);

        for (int i = 0; i < 8; i++) wr(6'(i), 32'(i * 3), 4'h0);
        for (int i = 0; i < 8; i++) rd(6'(i));
        idle(4);

        wr(6'd50, 32'h5, 4'h0);
        rd(6'd50);
        wr(6'd47, 32'h7, 4'h0);
        rd(6'd47);
        for (int i = 0; i < 64; i++) rd(6'(i));
        idle(4);

        wr(6'd9, 32'h12345678, 4'h0);
        rd(6'd9);
        step(1'b1, 1'b1, 1'b1, 4'hf, 6'd0, 32'h0);
        idle(20);
        step(1'b1, 1'b1, 1'b1, 4'hf, 6'd0, 32'h0);
        measure_init(0);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom), 4'($urandom), 6'($urandom_range(0, 63)), $urandom);
        end
        idle(75);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
